// File: rtl/router_pkt_reader.sv
// router_pkt_reader
//   Destination-side reader for one router output port. Drains the port FIFO
//   one byte every other cycle, reassembles header / payload / parity, checks
//   parity, aborts packets that stop making progress, and presents a byte
//   stream with start/end markers plus per-packet status.
//
// Handshake: read_en is a one-cycle strobe into the port FIFO. It is only
//   raised when vld_out=1 and no read was issued the cycle before, so the
//   registered (one-cycle-late) vld_out is always accurate when it is used.
//   The byte read in cycle k appears on data_out in k+1, is captured at the
//   end of k+1 and shows on pkt_data with pkt_data_valid in k+2. Downstream
//   has no back-pressure on pkt_data_valid; sink_ready only throttles the
//   issue of payload and parity reads.
//
// Ports:
//   clock, resetn           clock, synchronous active-low reset
//   vld_out, data_out       port FIFO not-empty flag and read data
//   sink_ready              downstream can take another byte
//   read_en                 FIFO read strobe
//   pkt_data/_valid         captured byte and its one-cycle valid
//   pkt_sop, pkt_eop        header / parity markers (with pkt_data_valid)
//   pkt_addr, pkt_len       header fields, latched at header capture
//   pkt_done, parity_err    end-of-packet pulse and parity mismatch pulse
//   trunc_err               pulse when a packet is abandoned on timeout
//   busy                    FSM is not IDLE
//   pkt_cnt, err_cnt        completed packets (wraps), errors (saturates)
//   fsm_state               current FSM state (0 IDLE,1 HDR,2 PAY,3 PAR)
module router_pkt_reader #(
  parameter int TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        vld_out,
  input  logic [7:0]  data_out,
  input  logic        sink_ready,
  output logic        read_en,
  output logic [7:0]  pkt_data,
  output logic        pkt_data_valid,
  output logic        pkt_sop,
  output logic        pkt_eop,
  output logic [1:0]  pkt_addr,
  output logic [5:0]  pkt_len,
  output logic        pkt_done,
  output logic        parity_err,
  output logic        trunc_err,
  output logic        busy,
  output logic [15:0] pkt_cnt,
  output logic [7:0]  err_cnt,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_PAY  = 2'd2,
    S_PAR  = 2'd3
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  logic        rd_pend;     // a read was issued last cycle; data_out is valid now
  logic [6:0]  remain;      // payload bytes still to capture
  logic [7:0]  acc;         // running XOR of header and payload
  logic [7:0]  tmo_cnt;
  logic        done_pend;   // parity byte captured last cycle
  logic        perr_pend;   // ...and it mismatched
  logic        issue;
  logic        capture;
  logic        abort;
  logic        tmo_count;

  // Next-state and read-issue decision.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    abort     = 1'b0;
    capture   = rd_pend && (state != S_IDLE);
    case (state)
      S_IDLE: begin
        // Header read is not gated by sink_ready.
        if (vld_out && !rd_pend) begin
          issue     = 1'b1;
          state_nxt = S_HDR;
        end
      end
      S_HDR: begin
        if (capture) begin
          state_nxt = (data_out[7:2] == 6'd0) ? S_PAR : S_PAY;
        end
      end
      S_PAY: begin
        if (capture) begin
          if (remain == 7'd1) state_nxt = S_PAR;
        end else if (vld_out && sink_ready && (remain != 7'd0)) begin
          issue = 1'b1;
        end
      end
      S_PAR: begin
        if (capture) begin
          state_nxt = S_IDLE;
        end else if (vld_out && sink_ready) begin
          issue = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // A cycle with neither a read issued nor a byte arriving is "no progress".
    // A capture always implies rd_pend, so capture wins over a timeout.
    tmo_count = (state != S_IDLE) && !issue && !rd_pend;
    if (tmo_count && (tmo_cnt == TMO_LAST)) begin
      abort     = 1'b1;
      state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      rd_pend        <= 1'b0;
      remain         <= 7'd0;
      acc            <= 8'd0;
      tmo_cnt        <= 8'd0;
      done_pend      <= 1'b0;
      perr_pend      <= 1'b0;
      pkt_data       <= 8'd0;
      pkt_data_valid <= 1'b0;
      pkt_sop        <= 1'b0;
      pkt_eop        <= 1'b0;
      pkt_addr       <= 2'd0;
      pkt_len        <= 6'd0;
      pkt_done       <= 1'b0;
      parity_err     <= 1'b0;
      trunc_err      <= 1'b0;
      pkt_cnt        <= 16'd0;
      err_cnt        <= 8'd0;
    end else begin
      rd_pend        <= issue;
      pkt_data_valid <= capture;
      pkt_sop        <= capture && (state == S_HDR);
      pkt_eop        <= capture && (state == S_PAR);
      if (capture) pkt_data <= data_out;

      if (state == S_IDLE)
        acc <= 8'd0;
      else if (capture && (state != S_PAR))
        acc <= acc ^ data_out;

      if (capture && (state == S_HDR)) begin
        pkt_addr <= data_out[1:0];
        pkt_len  <= data_out[7:2];
        remain   <= {1'b0, data_out[7:2]};
      end else if (capture && (state == S_PAY)) begin
        remain <= remain - 7'd1;
      end

      // Packet status is reported one cycle after the parity beat.
      done_pend  <= capture && (state == S_PAR);
      perr_pend  <= capture && (state == S_PAR) && (acc != data_out);
      pkt_done   <= done_pend;
      parity_err <= perr_pend;
      trunc_err  <= abort;

      if (done_pend) pkt_cnt <= pkt_cnt + 16'd1;
      if ((perr_pend || abort) && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;

      if (tmo_count && !abort) tmo_cnt <= tmo_cnt + 8'd1;
      else                     tmo_cnt <= 8'd0;
    end
  end

  assign read_en   = issue && resetn;
  assign busy      = (state != S_IDLE);
  assign fsm_state = state;

endmodule

// File: doc/router_pkt_reader.md
# router_pkt_reader

Destination-side packet reader attached to one output port of the 1x3 router. It drains the port's output FIFO through the `read_en`/`data_out` interface and reassembles each packet: header, payload and parity byte. It checks parity, detects packets abandoned by a router soft reset, and presents a byte stream with start/end markers and per-packet status to the downstream sink. One instance sits on each of the three router output ports.

## Interface
- `TIMEOUT`, default 64: cycles with no progress mid-packet before abort. Legal range 32–255; must exceed the router's 30-cycle soft-reset window.
- `clock`  in  1  system clock, all logic on rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `vld_out`  in  1  port FIFO not-empty (= ~empty; registered in FIFO, lags its true state by one cycle).
- `data_out`  in  8  FIFO read data; valid the cycle after a read is issued.
- `sink_ready`  in  1  downstream can accept a byte; gates issue of payload/parity reads only.
- `read_en`  out  1  FIFO read strobe.
- `pkt_data`  out  8  captured byte (header, payload or parity).
- `pkt_data_valid`  out  1  one-cycle pulse per captured byte.
- `pkt_sop`  out  1  with `pkt_data_valid`, marks the header byte.
- `pkt_eop`  out  1  with `pkt_data_valid`, marks the parity byte.
- `pkt_addr`  out  2  header[1:0], latched at header capture.
- `pkt_len`  out  6  header[7:2], latched at header capture.
- `pkt_done`  out  1  one-cycle pulse after the parity byte is captured.
- `parity_err`  out  1  one-cycle pulse with `pkt_done` when parity mismatches.
- `trunc_err`  out  1  one-cycle pulse on timeout abort.
- `busy`  out  1  high in any state other than IDLE.
- `pkt_cnt`  out  16  packets completed; wraps.
- `err_cnt`  out  8  parity plus truncation errors; saturates at 255.

## Operation
- Packet format: header {len[5:0], addr[1:0]}, then len payload bytes, then parity byte = XOR of header and all payload bytes. len = 0 is legal (header then parity).
- FSM states:
  - IDLE → HDR on issuing a read with `vld_out`=1.
  - HDR → PAY on header capture; HDR → PAR instead if len = 0.
  - PAY → PAR when the remaining-byte counter reaches 0.
  - PAR → IDLE on parity capture, pulsing `pkt_done`.
  - Any of HDR/PAY/PAR → IDLE on timeout.
- Read issue rule: `read_en` asserts in cycle k only if all of the following hold:
  - `vld_out`=1 in cycle k;
  - no read was issued in cycle k-1;
  - bytes remain in the current packet (or the state is IDLE);
  - `sink_ready`=1, unless this is the header read.
  - The alternate-cycle rule guarantees `vld_out` is accurate, so no read ever targets an empty FIFO. Maximum throughput is one byte per 2 cycles.
- Capture: a `rd_pend` flag is set in cycle k+1 after a read in cycle k. `data_out` is sampled at the end of k+1 and presented registered in cycle k+2.
- Remaining counter: 7 bits, loaded with len at header capture, decremented per payload capture.
- Running XOR: 8 bits, cleared in IDLE, accumulates header and payload. `parity_err` = (acc != parity byte).
- Timeout counter:
  - Counts in HDR/PAY/PAR on cycles with no read issued and `rd_pend`=0; clears on any issue.
  - Reaching `TIMEOUT` pulses `trunc_err`, increments `err_cnt` and returns to IDLE with no `pkt_done`.
  - Stalls caused by `sink_ready`=0 also count.
- A read is never issued beyond the packet's byte count. Bytes of the next packet stay in the FIFO until IDLE.
- Reset values: `read_en`, `pkt_data_valid`, `pkt_sop`, `pkt_eop`, `pkt_done`, `parity_err`, `trunc_err`, `busy` = 0; `pkt_data`, `pkt_addr`, `pkt_len`, `pkt_cnt`, `err_cnt` = 0; state IDLE.
- Reset mid-packet: in-flight data is discarded and no pulses are emitted on the following cycle.

## Timing
- Header read at cycle k: `pkt_sop`/`pkt_data_valid` in k+2; `pkt_len`/`pkt_addr` updated in k+2.
- Earliest next read is k+2. A packet of length L with the FIFO pre-filled completes in 2(L+2) cycles from the first `read_en`.
- `pkt_done`, `parity_err`, `pkt_cnt`/`err_cnt` update: cycle after the `pkt_eop` beat. The next header read may issue in that same cycle.
- Simultaneous timeout and capture: capture wins and the timeout counter clears.

## Test plan
- FIFO holds header 0x11 (len 4, addr 1), payload 0xA0,0xA1,0xA2,0xA3, parity 0x11^0xA0^0xA1^0xA2^0xA3 = 0x11 → `read_en` pulses at cycles 0,2,…,10; SOP with 0x11, EOP with 0x11; `pkt_done` at 13; `parity_err`=0; `pkt_cnt`=1.
- Same packet with parity 0x12 → `parity_err` pulse with `pkt_done`; `err_cnt`=1; `pkt_cnt`=1.
- len = 0 header 0x02, parity 0x02 → exactly 2 reads; SOP then EOP; `pkt_done`; no PAY state visited.
- Header 0x20 (len 8), then `vld_out` held 0 after 3 payload bytes → `trunc_err` after 64 idle cycles; state IDLE; `err_cnt`=1; no `pkt_done`.
- `sink_ready` low for 10 cycles mid-payload → no `read_en` during the stall; packet completes with correct data and parity; no timeout.
- Two back-to-back packets with `resetn` pulsed low during the first packet's payload → all outputs 0 after reset; the second packet reads cleanly.
